// File: rtl/dport_pkg.sv
// Shared types and constants for the data-port memory responder.
package dport_pkg;

    localparam int TAG_W       = 11;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    // Fibonacci LFSR, taps 16,14,13,11, shifting right: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             is_rd;
    } resp_stage_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {^(state & LFSR_TAPS), state[15:1]};
    endfunction

endpackage

// File: rtl/dport_ram.sv
// Single-port byte-writable RAM with a one-cycle registered read and no reset.
module dport_ram #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

`ifndef SYNTHESIS
    // Preload hook for benches; lands on the next scheduling region like a normal write.
    task automatic write(input logic [ADDR_W-1:0] waddr, input logic [31:0] wword);
        mem[waddr] <= wword;
    endtask
`endif

endmodule

// File: rtl/dport_mem_responder.sv
// Target end of the core's mem_d_* port: local RAM window plus fixed-latency
// in-order acks, with an optional LFSR accept throttle for stall stress.
module dport_mem_responder
    import dport_pkg::*;
#(
    parameter int          MEM_ADDR_W = 15,
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          LATENCY    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_en_i,
    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    output logic [31:0]      mem_d_data_rd_o,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o
);

    localparam int HI_LSB = MEM_ADDR_W + 2;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $fatal(1, "dport_mem_responder: LATENCY %0d outside %0d..%0d",
               LATENCY, LATENCY_MIN, LATENCY_MAX);
    end

    logic [15:0]           lfsr_reg;
    logic                  req;
    logic                  accept;
    logic                  take;
    logic                  in_range;
    logic                  is_access;
    logic                  req_err;
    logic [MEM_ADDR_W-1:0] ram_addr;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;
    resp_stage_t           stage_in;
    resp_stage_t           stage_q [1:LATENCY];
    logic [31:0]           data_q  [1:LATENCY];
    resp_stage_t           last;
    logic                  unused_inputs;

    assign unused_inputs = &{1'b0, mem_d_cacheable_i, mem_d_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    // Accept depends only on reset, throttle enable and the LFSR, never on the request.
    assign accept    = !rst_i & (!stall_en_i | lfsr_reg[0]);
    assign req       = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                     | mem_d_writeback_i | mem_d_flush_i;
    assign take      = req & accept;
    assign in_range  = mem_d_addr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB];
    assign is_access = mem_d_rd_i | (|mem_d_wr_i);
    assign req_err   = is_access & (!in_range | (mem_d_rd_i & (|mem_d_wr_i)));

    assign ram_addr = mem_d_addr_i[MEM_ADDR_W+1:2];
    assign ram_we   = (take & in_range & !mem_d_rd_i) ? mem_d_wr_i : 4'b0000;

    dport_ram #(
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk   (clk_i),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (mem_d_data_wr_i),
        .rdata (ram_rdata)
    );

    assign stage_in = '{valid: take,
                        tag:   mem_d_req_tag_i,
                        err:   req_err,
                        is_rd: mem_d_rd_i & !req_err};

    // Stage 1 picks up the registered RAM output; later stages just carry it along.
    for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_stage
        resp_stage_t stage_reg;

        if (gi == 1) begin : g_head
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_in;
                end
            end
            assign data_q[gi] = (stage_reg.valid & stage_reg.is_rd) ? ram_rdata : 32'h0;
        end else begin : g_tail
            logic [31:0] data_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    stage_reg <= '0;
                    data_reg  <= '0;
                end else begin
                    stage_reg <= stage_q[gi-1];
                    data_reg  <= data_q[gi-1];
                end
            end
            assign data_q[gi] = data_reg;
        end

        assign stage_q[gi] = stage_reg;
    end

    assign last             = stage_q[LATENCY];
    assign mem_d_accept_o   = accept;
    assign mem_d_ack_o      = last.valid;
    assign mem_d_error_o    = last.valid & last.err;
    assign mem_d_resp_tag_o = last.valid ? last.tag : '0;
    assign mem_d_data_rd_o  = (last.valid & last.is_rd) ? data_q[LATENCY] : 32'h0;

endmodule
